// File: rtl/s2p_frame_ctrl.sv
// Serial-to-parallel frame receiver: MSB-first data, optional parity bit,
// single-entry output buffer with ready/valid handoff and sticky error flags.
module s2p_frame_ctrl #(
  parameter int WIDTH      = 8,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_start,
  input  logic             ser_bit,
  input  logic             ser_stb,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             parity_err,
  output logic             overrun,
  input  logic             clr_err
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             parity_err_q, parity_err_d;
  logic             overrun_q, overrun_d;

  logic             done, good;
  logic [WIDTH-1:0] word;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    done    = 1'b0;
    good    = 1'b0;
    word    = shreg_q;
    case (state_q)
      IDLE: begin
        if (ser_start) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        // A new start always wins over a strobe in the same cycle.
        if (ser_start) begin
          cnt_d = '0;
        end else if (ser_stb) begin
          shreg_d = {shreg_q[WIDTH-2:0], ser_bit};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            if (PARITY_EN) begin
              state_d = PARITY;
            end else begin
              state_d = IDLE;
              done    = 1'b1;
              good    = 1'b1;
              word    = shreg_d;
            end
          end
        end
      end
      PARITY: begin
        if (ser_start) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else if (ser_stb) begin
          state_d = IDLE;
          done    = 1'b1;
          good    = ((^shreg_q) ^ ser_bit) == ODD_PARITY;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    parity_err_d = parity_err_q;
    overrun_d    = overrun_q;
    if (clr_err) begin
      parity_err_d = 1'b0;
      overrun_d    = 1'b0;
    end
    if (dout_valid_q && dout_ready)
      dout_valid_d = 1'b0;
    // Set events are evaluated after the clear so they take priority.
    if (done) begin
      if (!good) begin
        parity_err_d = 1'b1;
      end else if (!dout_valid_q || dout_ready) begin
        dout_d       = word;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q != IDLE);
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Directed bench for s2p_frame_ctrl (defaults: 8 data bits, even parity).
module tb_s2p_frame_ctrl;
  logic       clk = 1'b0;
  logic       rst, ser_start, ser_bit, ser_stb, dout_ready, clr_err;
  logic [7:0] dout;
  logic       dout_valid, busy, parity_err, overrun;
  int         checks = 0;
  int         errors = 0;

  s2p_frame_ctrl dut (
    .clk(clk), .rst(rst), .ser_start(ser_start), .ser_bit(ser_bit),
    .ser_stb(ser_stb), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .busy(busy), .parity_err(parity_err),
    .overrun(overrun), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start();
    ser_start = 1'b1;
    tick();
    ser_start = 1'b0;
  endtask

  task automatic sbit(input logic b);
    ser_stb = 1'b1;
    ser_bit = b;
    tick();
    ser_stb = 1'b0;
    ser_bit = 1'b0;
  endtask

  task automatic data_bits(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) sbit(d[i]);
  endtask

  task automatic frame(input logic [7:0] d, input logic p);
    start();
    data_bits(d);
    sbit(p);
  endtask

  initial begin
    rst = 1'b1; ser_start = 1'b0; ser_bit = 1'b0; ser_stb = 1'b0;
    dout_ready = 1'b0; clr_err = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ovr", overrun, 0);

    // Good frame 0xA5, even parity bit 0
    start();
    chk("a5_busy_shift", busy, 1);
    data_bits(8'hA5);
    chk("a5_busy_par", busy, 1);
    chk("a5_valid_before", dout_valid, 0);
    sbit(1'b0);
    chk("a5_valid", dout_valid, 1);
    chk("a5_dout", dout, 32'hA5);
    chk("a5_perr", parity_err, 0);
    chk("a5_idle", busy, 0);
    tick();
    chk("a5_hold", dout, 32'hA5);
    dout_ready = 1'b1; tick(); dout_ready = 1'b0;
    chk("a5_drain", dout_valid, 0);

    // Bad parity, then clear
    frame(8'hA5, 1'b1);
    chk("bad_valid", dout_valid, 0);
    chk("bad_perr", parity_err, 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("clr_perr", parity_err, 0);

    // Clear coincident with a parity failure: the set wins
    start();
    data_bits(8'hA5);
    clr_err = 1'b1;
    sbit(1'b1);
    clr_err = 1'b0;
    chk("clr_vs_set", parity_err, 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;

    // Overrun: ready held low across two good frames
    frame(8'h3C, 1'b0);
    chk("ov_first", dout, 32'h3C);
    frame(8'hC3, 1'b0);
    chk("ov_dout", dout, 32'h3C);
    chk("ov_flag", overrun, 1);
    chk("ov_valid", dout_valid, 1);
    dout_ready = 1'b1; tick(); dout_ready = 1'b0;
    chk("ov_drain", dout_valid, 0);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("ov_clr", overrun, 0);

    // Abort after 4 data bits, then full frame 0x81
    start();
    sbit(1); sbit(0); sbit(1); sbit(0);
    chk("abort_novalid", dout_valid, 0);
    frame(8'h81, 1'b0);
    chk("abort_dout", dout, 32'h81);
    chk("abort_valid", dout_valid, 1);
    chk("abort_perr", parity_err, 0);
    chk("abort_ovr", overrun, 0);
    dout_ready = 1'b1; tick(); dout_ready = 1'b0;

    // Reset mid-frame with a pending word and a set flag
    frame(8'h5A, 1'b1);
    frame(8'h81, 1'b0);
    chk("pre_rst_perr", parity_err, 1);
    start();
    for (int i = 0; i < 5; i++) sbit(1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_valid", dout_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_perr", parity_err, 0);
    // Strobes with no start are ignored
    for (int i = 0; i < 9; i++) sbit(1'b0);
    chk("nostart_valid", dout_valid, 0);
    chk("nostart_busy", busy, 0);

    // Completion coincident with ready on a pending word
    frame(8'h3C, 1'b0);
    chk("coin_first", dout, 32'h3C);
    start();
    data_bits(8'hC3);
    dout_ready = 1'b1;
    sbit(1'b0);
    dout_ready = 1'b0;
    chk("coin_valid", dout_valid, 1);
    chk("coin_dout", dout, 32'hC3);
    chk("coin_ovr", overrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/s2p_frame_ctrl.md
S2P_FRAME_CTRL -- requirements
Module: s2p_frame_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data bits per frame (legal range 2..16).
REQ-002 SHALL provide parameter PARITY_EN, default 1; when 1, one parity bit follows the data bits.
REQ-003 SHALL provide parameter ODD_PARITY, default 0; 0 = even parity, 1 = odd parity.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 ser_start  in  1  single-cycle start-of-frame pulse.
REQ-007 ser_bit  in  1  serial data, sampled only when ser_stb=1.
REQ-008 ser_stb  in  1  bit strobe, one cycle per serial bit.
REQ-009 dout  out  WIDTH  assembled parallel word.
REQ-010 dout_valid  out  1  dout holds an undelivered word.
REQ-011 dout_ready  in  1  consumer accepts dout when dout_valid=1.
REQ-012 busy  out  1  frame reception in progress.
REQ-013 parity_err  out  1  sticky parity-failure flag.
REQ-014 overrun  out  1  sticky flag, word dropped because output buffer was full.
REQ-015 clr_err  in  1  single-cycle clear of parity_err and overrun.

Function
REQ-016 SHALL implement states IDLE, SHIFT, PARITY; busy=1 in SHIFT and PARITY, 0 in IDLE.
REQ-017 IDLE: ser_start=1 -> SHIFT with bit counter=0; ser_stb in the ser_start cycle is ignored.
REQ-018 SHIFT: each ser_stb shifts MSB-first (shreg <= {shreg[WIDTH-2:0], ser_bit}) and increments the counter.
REQ-019 SHIFT: the WIDTH-th strobe -> PARITY if PARITY_EN=1, else completes the frame and returns to IDLE.
REQ-020 PARITY: next ser_stb samples parity bit, completes the frame, returns to IDLE.
REQ-021 Parity check: XOR of data bits and parity bit SHALL be 0 (even) or 1 (odd); mismatch sets parity_err and discards the word.
REQ-022 Frame completion with good word: if dout_valid=0, or dout_valid=1 and dout_ready=1 in that same cycle, dout loads the word and dout_valid=1 from the next cycle.
REQ-023 Frame completion with dout_valid=1 and dout_ready=0: word discarded, overrun set, dout unchanged.
REQ-024 Latency: dout_valid SHALL rise exactly one cycle after the clock edge sampling the final strobe (data or parity).
REQ-025 dout_valid=1 and dout_ready=1 with no completing frame -> dout_valid=0 next cycle; dout SHALL be stable while dout_valid=1.
REQ-026 ser_start in SHIFT or PARITY SHALL abort the current frame without output or flags and restart at counter=0 in SHIFT.
REQ-027 ser_stb without active frame (IDLE) SHALL be ignored.
REQ-028 clr_err clears both sticky flags next cycle; a flag-setting event in the same cycle SHALL win (flag remains 1).
REQ-029 Counter SHALL be ceil(log2(WIDTH+1)) bits and never wrap within a frame.

Reset
REQ-030 rst=1 SHALL force state IDLE, counter=0, shreg=0, dout=0, dout_valid=0, busy=0, parity_err=0, overrun=0 at the next edge, overriding all inputs including mid-frame.
REQ-031 First frame after reset release SHALL require a fresh ser_start.

Verification
REQ-032 Defaults; start, strobes 1,0,1,0,0,1,0,1, parity 0 -> dout=0xA5, dout_valid rises one cycle after parity strobe, parity_err=0.
REQ-033 Same data, parity bit 1 -> no dout_valid, parity_err=1; clr_err pulse -> parity_err=0.
REQ-034 dout_ready held 0; two good frames 0x3C then 0xC3 -> dout stays 0x3C, overrun=1; dout_ready=1 -> dout_valid=0 next cycle.
REQ-035 ser_start after 4 data bits, then full frame 0x81 -> single dout=0x81, no flags.
REQ-036 rst asserted after 5 strobes -> all outputs 0 next cycle; strobes without ser_start produce no output.
REQ-037 Completion cycle coincident with dout_ready=1 on pending word -> new word loaded, dout_valid stays 1, overrun=0.
